// File: rtl/vm_multi_if.sv
// rtl/vm_multi_if.sv - front-end/back-end signal bundle for the vending controller
interface vm_multi_if #(
  parameter int PRICE_W = 5,
  parameter int CNT_W   = 6,
  parameter int MON_W   = 9
);
  logic               in_item_valid;
  logic [PRICE_W-1:0] in_item_price;
  logic [CNT_W-1:0]   in_item_stock;
  logic               in_coin_valid;
  logic [5:0]         in_coin;
  logic               in_rtn_coin;
  logic [2:0]         in_buy_item;
  logic [MON_W-1:0]   out_monitor;
  logic               out_valid;
  logic [3:0]         out_consumer;
  logic [CNT_W-1:0]   out_sell_num;
  logic [1:0]         out_status;

  modport master (
    output in_item_valid, in_item_price, in_item_stock,
    output in_coin_valid, in_coin, in_rtn_coin, in_buy_item,
    input  out_monitor, out_valid, out_consumer, out_sell_num, out_status
  );

  modport slave (
    input  in_item_valid, in_item_price, in_item_stock,
    input  in_coin_valid, in_coin, in_rtn_coin, in_buy_item,
    output out_monitor, out_valid, out_consumer, out_sell_num, out_status
  );
endinterface

// File: rtl/vm_multi.sv
// rtl/vm_multi.sv - multi-slot vending controller with stock, status and credit saturation
module vm_multi #(
  parameter int N_ITEM  = 6,
  parameter int PRICE_W = 5,
  parameter int CNT_W   = 6,
  parameter int MON_W   = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  vm_multi_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_COIN   = 3'd2,
    S_DECIDE = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  localparam logic [1:0] ST_BUY  = 2'd0;
  localparam logic [1:0] ST_POOR = 2'd1;
  localparam logic [1:0] ST_REJ  = 2'd2;
  localparam logic [1:0] ST_RTN  = 2'd3;

  localparam logic [MON_W-1:0] C50 = MON_W'(50);
  localparam logic [MON_W-1:0] C20 = MON_W'(20);
  localparam logic [MON_W-1:0] C10 = MON_W'(10);
  localparam logic [MON_W-1:0] C5  = MON_W'(5);

  state_t             state_q, state_d;
  logic [2:0]         load_idx_q, load_idx_d;
  logic [2:0]         win_idx_q, win_idx_d;
  logic [MON_W-1:0]   credit_q, credit_d;
  logic               rtn_q, rtn_d;
  logic [2:0]         buy_q, buy_d;
  logic [1:0]         status_q, status_d;
  logic [MON_W-1:0]   change_q, change_d;
  logic [PRICE_W-1:0] price_q [N_ITEM];
  logic [PRICE_W-1:0] price_d [N_ITEM];
  logic [CNT_W-1:0]   stock_q [N_ITEM];
  logic [CNT_W-1:0]   stock_d [N_ITEM];
  logic [CNT_W-1:0]   sell_q  [N_ITEM];
  logic [CNT_W-1:0]   sell_d  [N_ITEM];

  logic [MON_W:0]     coin_sum;
  logic [MON_W-1:0]   credit_sat;
  logic [PRICE_W-1:0] sel_price;
  logic [CNT_W-1:0]   sel_stock;
  logic [MON_W-1:0]   r50, r20, r10, r5;

  // Saturating credit update and lookup of the selected slot's price/stock
  always_comb begin
    coin_sum   = {1'b0, credit_q} + {{(MON_W-5){1'b0}}, bus.in_coin};
    credit_sat = coin_sum[MON_W] ? '1 : coin_sum[MON_W-1:0];
    sel_price  = '0;
    sel_stock  = '0;
    for (int k = 0; k < N_ITEM; k++) begin
      if (buy_q == 3'(k + 1)) begin
        sel_price = price_q[k];
        sel_stock = stock_q[k];
      end
    end
  end

  // State register and all datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      load_idx_q <= '0;
      win_idx_q  <= '0;
      credit_q   <= '0;
      rtn_q      <= 1'b0;
      buy_q      <= '0;
      status_q   <= '0;
      change_q   <= '0;
      for (int k = 0; k < N_ITEM; k++) begin
        price_q[k] <= '0;
        stock_q[k] <= '0;
        sell_q[k]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      load_idx_q <= load_idx_d;
      win_idx_q  <= win_idx_d;
      credit_q   <= credit_d;
      rtn_q      <= rtn_d;
      buy_q      <= buy_d;
      status_q   <= status_d;
      change_q   <= change_d;
      for (int k = 0; k < N_ITEM; k++) begin
        price_q[k] <= price_d[k];
        stock_q[k] <= stock_d[k];
        sell_q[k]  <= sell_d[k];
      end
    end
  end

  // Next-state logic: load slots, accumulate coins, decode the command, run the window
  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    win_idx_d  = win_idx_q;
    credit_d   = credit_q;
    rtn_d      = rtn_q;
    buy_d      = buy_q;
    status_d   = status_q;
    change_d   = change_q;
    price_d    = price_q;
    stock_d    = stock_q;
    sell_d     = sell_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_item_valid) begin
          // The first load beat arrives in IDLE and already belongs to slot 1
          price_d[0] = bus.in_item_price;
          stock_d[0] = bus.in_item_stock;
          load_idx_d = 3'd1;
          state_d    = S_LOAD;
        end else if (bus.in_coin_valid) begin
          credit_d = credit_sat;
          state_d  = S_COIN;
        end
      end
      S_LOAD: begin
        for (int k = 0; k < N_ITEM; k++) begin
          if (load_idx_q == 3'(k)) begin
            price_d[k] = bus.in_item_price;
            stock_d[k] = bus.in_item_stock;
          end
        end
        if (load_idx_q == 3'(N_ITEM - 1)) begin
          for (int k = 0; k < N_ITEM; k++) begin
            sell_d[k] = '0;
          end
          load_idx_d = '0;
          state_d    = S_IDLE;
        end else begin
          load_idx_d = load_idx_q + 3'd1;
        end
      end
      S_COIN: begin
        if (bus.in_coin_valid) begin
          credit_d = credit_sat;
        end else begin
          rtn_d   = bus.in_rtn_coin;
          buy_d   = bus.in_buy_item;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        change_d = '0;
        if (rtn_q || (buy_q == 3'd0)) begin
          status_d = ST_RTN;
          change_d = credit_q;
          credit_d = '0;
        end else if (({1'b0, buy_q} > 4'(N_ITEM)) || (sel_stock == '0)) begin
          status_d = ST_REJ;
        end else if (credit_q < {{(MON_W-PRICE_W){1'b0}}, sel_price}) begin
          status_d = ST_POOR;
        end else begin
          status_d = ST_BUY;
          change_d = credit_q - {{(MON_W-PRICE_W){1'b0}}, sel_price};
          credit_d = '0;
          for (int k = 0; k < N_ITEM; k++) begin
            if (buy_q == 3'(k + 1)) begin
              stock_d[k] = stock_q[k] - 1'b1;
              sell_d[k]  = sell_q[k] + 1'b1;
            end
          end
        end
        win_idx_d = '0;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (win_idx_q == 3'(N_ITEM - 1)) begin
          win_idx_d = '0;
          state_d   = S_IDLE;
        end else begin
          win_idx_d = win_idx_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Serial window outputs: slot, greedy change breakdown and per-slot sell counts
  always_comb begin
    r50 = change_q % C50;
    r20 = r50 % C20;
    r10 = r20 % C10;
    r5  = r10 % C5;
    bus.out_valid    = (state_q == S_OUT);
    bus.out_status   = bus.out_valid ? status_q : 2'd0;
    bus.out_sell_num = '0;
    bus.out_consumer = '0;
    if (bus.out_valid) begin
      for (int k = 0; k < N_ITEM; k++) begin
        if (win_idx_q == 3'(k)) begin
          bus.out_sell_num = sell_q[k];
        end
      end
      if ((status_q == ST_BUY) || (status_q == ST_RTN)) begin
        case (win_idx_q)
          3'd0:    bus.out_consumer = (status_q == ST_BUY) ? {1'b0, buy_q} : 4'd0;
          3'd1:    bus.out_consumer = 4'(change_q / C50);
          3'd2:    bus.out_consumer = 4'(r50 / C20);
          3'd3:    bus.out_consumer = 4'(r20 / C10);
          3'd4:    bus.out_consumer = 4'(r10 / C5);
          3'd5:    bus.out_consumer = 4'(r5);
          default: bus.out_consumer = 4'd0;
        endcase
      end
    end
  end

  assign bus.out_monitor = credit_q;

endmodule

// File: doc/vm_multi.md
Name: vm_multi

Overview:
- Parametrised vending-machine controller for N_ITEM item slots.
- Adds per-slot stock tracking, sold-out rejection, an explicit result status code and credit saturation.
- Sits between the coin/keypad front end and the display/dispenser back end. Results and change are reported serially in a fixed-length output window.

Parameters:
- N_ITEM, 6, number of item slots; legal range 6..7.
- PRICE_W, 5, item price width in dollars.
- CNT_W, 6, stock and sell-count width.
- MON_W, 9, credit width; legal range 7..9, so that every change count fits in 4 bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- in_item_valid  in  1  high for exactly N_ITEM consecutive cycles during a slot load.
- in_item_price  in  PRICE_W  price of slot k, k = 1..N_ITEM in load order.
- in_item_stock  in  CNT_W  initial stock of slot k.
- in_coin_valid  in  1  coin present this cycle.
- in_coin  in  6  coin value (1, 5, 10, 20 or 50).
- in_rtn_coin  in  1  return-credit request; sampled in the command cycle.
- in_buy_item  in  3  selected slot 1..N_ITEM (0 = none); sampled in the command cycle.
- out_monitor  out  MON_W  current credit.
- out_valid  out  1  result window active.
- out_consumer  out  4  serial dispense/change data.
- out_sell_num  out  CNT_W  serial sell counts.
- out_status  out  2  result code: 0 bought, 1 insufficient, 2 rejected/sold-out, 3 returned.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk, all state on its rising edge.
- Every register clears on reset: prices, stock, sell counts, credit, FSM, and all outputs (out_monitor, out_valid, out_consumer, out_sell_num, out_status) to 0.
- Reset asserted mid-window aborts the window immediately. After reset, every buy attempt is sold-out because all stock is 0.
- FSM states:
  - IDLE to LOAD on in_item_valid; IDLE to COIN on in_coin_valid; otherwise IDLE holds.
  - LOAD: captures price/stock of slot k in the k-th in_item_valid cycle, then clears all sell counts. Credit is untouched. Returns to IDLE after N_ITEM cycles.
  - COIN: adds in_coin every in_coin_valid cycle. The first cycle with in_coin_valid = 0 is the command cycle C, in which in_rtn_coin and in_buy_item are sampled; the FSM then goes to DECIDE.
  - DECIDE: the single cycle C+1; computes the result. OUT then runs cycles C+2 .. C+N_ITEM+1, with out_valid = 1 throughout, then IDLE.
- Command decode, in priority order:
  1. in_rtn_coin = 1, or in_buy_item = 0 → return, status 3.
  2. in_buy_item > N_ITEM, or stock of that slot = 0 → status 2.
  3. credit < price → status 1.
  4. Otherwise buy → status 0.
- Buy success:
  - Stock is decremented and the sell count incremented; the sell count wraps modulo 2^CNT_W.
  - change = credit − price.
- Return: change = credit.
- Credit:
  - Saturates at 2^MON_W−1; excess coins are lost.
  - out_monitor is cleared to 0 from cycle C+2 on status 0 or 3.
  - On status 1 or 2 the credit is retained, and the FSM returns to IDLE with coins still accepted afterwards.
- OUT window, window cycle j = 0..N_ITEM−1:
  - out_sell_num = sell count of slot j+1, reflecting the current purchase.
  - out_status is constant for the whole window.
  - out_consumer, for status 0/3 only:
    - j = 0: purchased slot number (0 when returned).
    - j = 1..5: greedy change counts of 50, 20, 10, 5, 1.
    - j ≥ 6: 0.
  - For status 1/2, out_consumer = 0 in all window cycles.
- Outside the window, out_valid, out_consumer, out_sell_num and out_status are 0.
- Input protocol: in_item_valid and in_coin_valid are never driven during DECIDE/OUT or in cycle C. A load arriving while in COIN is not permitted.
- A new coin or load is accepted in the cycle right after the last OUT cycle.

Test Plan:
- Load prices 10, 20, 30, 5, 15, 25 and stock 2 each; coins 50 + 20; buy 3 → status 0. out_consumer 3, 0, 2, 0, 0, 0. out_sell_num 0, 0, 1, 0, 0, 0. out_monitor 0 from C+2.
- Credit 23, in_rtn_coin = 1 together with in_buy_item = 2 → status 3. out_consumer 0, 0, 1, 0, 0, 3. Stock unchanged.
- Credit 4, buy 4 (price 5) → status 1. out_consumer all 0 for 6 cycles. out_monitor stays 4. Further coin 1, buy 4 → status 0, change all 0.
- Stock-1 slot bought twice → second attempt status 2, credit retained. in_buy_item = 7 with N_ITEM = 6 → status 2.
- Insert 11 coins of 50 → out_monitor saturates at 511. Return → out_consumer 0, 10, 0, 1, 0, 1.
- Reset asserted in window cycle 3 → all outputs 0 immediately. After reset, buy 1 → status 2.
